// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause codes
// and the sequencing counter width.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    // Wide enough for the largest count the sequence reaches (hold + all stage gaps).
    function automatic int cnt_width(input int hold, input int stages, input int gap);
        return $clog2(hold + stages * gap + 2);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES rising edges.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: hold PC clear, release stage resets in order, then enable the core.
// Optional RST_CAUSE_EN adds rst_cause (2'b01 power-on/rst, 2'b10 soft reset).
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGE_GAP   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst,
    output logic                  clear_pc,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  enable,
    output logic                  busy
`ifdef RST_CAUSE_EN
    ,
    output logic [1:0]            rst_cause
`endif
);

    localparam int CW = cnt_width(HOLD_CYCLES, NUM_STAGES, STAGE_GAP);
    localparam logic [CW-1:0] LAST_HOLD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] EN_AT     = CW'(HOLD_CYCLES + NUM_STAGES * STAGE_GAP);

    logic sync_rst_n;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk        (clk),
        .rst        (rst),
        .sync_rst_n (sync_rst_n)
    );

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  clear_q, clear_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;

    // Counter value after edge T0+j equals j, so each release is a single compare.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_d  = clear_q;
        stage_d  = stage_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        if (soft_rst) begin
            state_d  = S_HOLD;
            cnt_d    = '0;
            clear_d  = 1'b1;
            stage_d  = '1;
            enable_d = 1'b0;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_HOLD) begin
                        clear_d = 1'b0;
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    cnt_d = cnt_q + 1'b1;
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (cnt_q == CW'(HOLD_CYCLES + (k + 1) * STAGE_GAP - 1))
                            stage_d[k] = 1'b0;
                    end
                    if (cnt_q == EN_AT) begin
                        enable_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: ;
                default: begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    clear_d  = 1'b1;
                    stage_d  = '1;
                    enable_d = 1'b0;
                    busy_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            clear_q  <= 1'b1;
            stage_q  <= '1;
            enable_q <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clear_q  <= clear_d;
            stage_q  <= stage_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
        end
    end

    assign clear_pc  = clear_q;
    assign stage_rst = stage_q;
    assign enable    = enable_q;
    assign busy      = busy_q;

`ifdef RST_CAUSE_EN
    logic [1:0] cause_q;

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n)   cause_q <= CAUSE_POR;
        else if (soft_rst) cause_q <= CAUSE_SOFT;
    end

    assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, negedge monitors compare.
module tb_reset_sequencer;
    import rst_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, soft_rst, rst1, soft_rst1;
    logic       clear_pc, enable, busy;
    logic [2:0] stage_rst;
    logic       clear_pc1, enable1, busy1;
    logic [0:0] stage_rst1;
`ifdef RST_CAUSE_EN
    logic [1:0] rst_cause, rst_cause1;
`endif

    reset_sequencer dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst),
        .clear_pc(clear_pc), .stage_rst(stage_rst), .enable(enable), .busy(busy)
`ifdef RST_CAUSE_EN
        , .rst_cause(rst_cause)
`endif
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst(rst1), .soft_rst(soft_rst1),
        .clear_pc(clear_pc1), .stage_rst(stage_rst1), .enable(enable1), .busy(busy1)
`ifdef RST_CAUSE_EN
        , .rst_cause(rst_cause1)
`endif
    );

    typedef struct {
        logic       clr;
        logic [2:0] st;
        logic       en;
        logic       bsy;
        logic [1:0] cause;
        string      tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    // Default schedule: clear_pc falls at T0+4, stages at +6/+8/+10, enable at +11.
    function automatic exp_t e0(input int j, input logic [1:0] c, input string t);
        exp_t e;
        e.clr   = (j < 4);
        e.st    = {(j < 10), (j < 8), (j < 6)};
        e.en    = (j >= 11);
        e.bsy   = (j < 11);
        e.cause = c;
        e.tag   = $sformatf("%s j=%0d", t, j);
        return e;
    endfunction

    // Minimal config: clear_pc at T0+1, stage at T0+2, enable at T0+3.
    function automatic exp_t e1(input int j, input logic [1:0] c, input string t);
        exp_t e;
        e.clr   = (j < 1);
        e.st    = {2'b00, (j < 2)};
        e.en    = (j >= 3);
        e.bsy   = (j < 3);
        e.cause = c;
        e.tag   = $sformatf("%s j=%0d", t, j);
        return e;
    endfunction

    task automatic tick0(input int j, input logic [1:0] c, input string t);
        @(posedge clk); #1;
        q0.push_back(e0(j, c, t));
    endtask

    task automatic tick1(input int j, input logic [1:0] c, input string t);
        @(posedge clk); #1;
        q1.push_back(e1(j, c, t));
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if ({clear_pc, stage_rst, enable, busy} !== {e.clr, e.st, e.en, e.bsy}) begin
                errors++;
                $display("FAIL dut %s: got clr=%b st=%b en=%b busy=%b, want clr=%b st=%b en=%b busy=%b",
                         e.tag, clear_pc, stage_rst, enable, busy, e.clr, e.st, e.en, e.bsy);
            end
`ifdef RST_CAUSE_EN
            checks++;
            if (rst_cause !== e.cause) begin
                errors++;
                $display("FAIL dut cause %s: got %b want %b", e.tag, rst_cause, e.cause);
            end
`endif
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({clear_pc1, stage_rst1, enable1, busy1} !== {e.clr, e.st[0], e.en, e.bsy}) begin
                errors++;
                $display("FAIL dut1 %s: got clr=%b st=%b en=%b busy=%b, want clr=%b st=%b en=%b busy=%b",
                         e.tag, clear_pc1, stage_rst1, enable1, busy1, e.clr, e.st[0], e.en, e.bsy);
            end
`ifdef RST_CAUSE_EN
            checks++;
            if (rst_cause1 !== e.cause) begin
                errors++;
                $display("FAIL dut1 cause %s: got %b want %b", e.tag, rst_cause1, e.cause);
            end
`endif
        end
    end

    initial begin
        rst = 1'b0; soft_rst = 1'b0; rst1 = 1'b0; soft_rst1 = 1'b0;

        // Power-on: rst low 3 cycles, release between edges, T0 is 2nd edge after.
        repeat (3) tick0(-5, CAUSE_POR, "por_hold");
        rst = 1'b1;
        for (int j = -1; j <= 14; j++) tick0(j, CAUSE_POR, "por_seq");

        // One-cycle soft reset while running.
        soft_rst = 1'b1;
        tick0(0, CAUSE_SOFT, "soft_run");
        soft_rst = 1'b0;
        for (int j = 1; j <= 6; j++) tick0(j, CAUSE_SOFT, "soft_run");

        // Soft reset at T0+7, after stage 0 released: restart, enable 11 later.
        soft_rst = 1'b1;
        tick0(0, CAUSE_SOFT, "soft_mid");
        soft_rst = 1'b0;
        for (int j = 1; j <= 13; j++) tick0(j, CAUSE_SOFT, "soft_mid");

        // Soft reset held for three edges pins the counter at zero.
        soft_rst = 1'b1;
        repeat (3) tick0(0, CAUSE_SOFT, "soft_held");
        soft_rst = 1'b0;
        for (int j = 1; j <= 7; j++) tick0(j, CAUSE_SOFT, "soft_held");

        // rst asserted between edges mid-release: outputs reset before next edge.
        @(posedge clk); #4;
        rst = 1'b0;
        q0.push_back(e0(-5, CAUSE_POR, "rst_mid"));
        repeat (2) tick0(-5, CAUSE_POR, "rst_mid_hold");
        rst = 1'b1;
        for (int j = -1; j <= 12; j++) tick0(j, CAUSE_POR, "rst_mid_seq");

        // Minimal config, 3-flop sync, release just before an edge.
        @(posedge clk); #8;
        rst1 = 1'b1;
        for (int j = -2; j <= 5; j++) tick1(j, CAUSE_POR, "min_por");
        soft_rst1 = 1'b1;
        tick1(0, CAUSE_SOFT, "min_soft");
        soft_rst1 = 1'b0;
        for (int j = 1; j <= 4; j++) tick1(j, CAUSE_SOFT, "min_soft");

        repeat (2) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
